// File: rtl/berger_fault_campaign.sv
// rtl/berger_fault_campaign.sv - Configurable fault-injection campaign between Berger encoder and checker
//
// Purpose:
//   Passes codewords through one register stage. While a campaign runs, every
//   period-th valid word is faulted using a single-bit, burst or walking mask
//   in toggle or unidirectional (1->0 / 0->1) mode.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_code, in_valid          codeword stream from the encoder
//   cfg_start, cfg_stop        campaign start (IDLE only) / abort pulses
//   cfg_mode                   0 toggle, 1 force 1->0, 2 force 0->1, 3 walking toggle
//   cfg_bit_addr               first faulted bit position
//   cfg_burst_len              adjacent bits faulted per injection
//   cfg_period                 inject on every cfg_period-th valid word
//   cfg_count                  injections to perform, 0 = until cfg_stop
//   out_code, out_valid        registered (possibly faulted) codeword stream
//   inj_flag, inj_mask         injection marker and mask for the current output word
//   busy, done                 campaign running / one-cycle completion pulse
module berger_fault_campaign #(
    parameter int CODE_W = 12,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_valid,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_bit_addr,
    input  logic [ADDR_W-1:0] cfg_burst_len,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    output logic              inj_flag,
    output logic [CODE_W-1:0] inj_mask,
    output logic              busy,
    output logic              done
);

    // One extra bit so a burst length of exactly CODE_W is representable.
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  per_cnt;
    logic [CNT_W-1:0]  inj_cnt;

    logic              start_ok;
    logic              period_hit;
    logic              inject;
    logic              last_inj;
    logic [LEN_W-1:0]  len_clamped;
    logic [CNT_W-1:0]  period_clamped;
    logic [ADDR_W-1:0] addr_walk;
    logic [CODE_W-1:0] mask;
    logic [CODE_W-1:0] faulted;

    assign start_ok   = (state == S_IDLE) && cfg_start;
    assign period_hit = (per_cnt == period_q - CNT_W'(1));
    // A same-cycle abort suppresses the injection so that word passes clean.
    assign inject     = (state == S_RUN) && in_valid && !cfg_stop && period_hit;
    assign last_inj   = (count_q != '0) && ((inj_cnt + CNT_W'(1)) == count_q);

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Config normalisation applied once, at the accepted start.
    always_comb begin
        len_clamped = LEN_W'(cfg_burst_len);
        if (cfg_burst_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (int'(cfg_burst_len) > CODE_W) begin
            len_clamped = LEN_W'(CODE_W);
        end
        period_clamped = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
    end

    // Walking mode step: next bit position, wrapping at CODE_W.
    always_comb begin
        addr_walk = ADDR_W'((int'(addr_q) + 1) % CODE_W);
    end

    // Burst mask wraps around the codeword; an out-of-range start bit
    // produces an empty mask while the word still counts as injected.
    always_comb begin
        int pos;
        mask = '0;
        pos  = 0;
        if (int'(addr_q) < CODE_W) begin
            for (int i = 0; i < CODE_W; i++) begin
                if (i < int'(len_q)) begin
                    pos = int'(addr_q) + i;
                    if (pos >= CODE_W) begin
                        pos = pos - CODE_W;
                    end
                    mask[pos] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (mode_q)
            2'd1:    faulted = in_code & ~mask;
            2'd2:    faulted = in_code | mask;
            default: faulted = in_code ^ mask;
        endcase
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cfg_stop) begin
                    state_next = S_IDLE;
                end else if (inject && last_inj) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latched campaign configuration and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            period_q <= '0;
            count_q  <= '0;
            per_cnt  <= '0;
            inj_cnt  <= '0;
        end else if (start_ok) begin
            mode_q   <= cfg_mode;
            addr_q   <= cfg_bit_addr;
            len_q    <= len_clamped;
            period_q <= period_clamped;
            count_q  <= cfg_count;
            per_cnt  <= '0;
            inj_cnt  <= '0;
        end else if ((state == S_RUN) && in_valid && !cfg_stop) begin
            if (period_hit) begin
                per_cnt <= '0;
                inj_cnt <= inj_cnt + CNT_W'(1);
                if (mode_q == 2'd3) begin
                    addr_q <= addr_walk;
                end
            end else begin
                per_cnt <= per_cnt + CNT_W'(1);
            end
        end
    end

    // Output pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_code  <= '0;
            out_valid <= 1'b0;
            inj_flag  <= 1'b0;
            inj_mask  <= '0;
        end else begin
            out_valid <= in_valid;
            if (inject) begin
                out_code <= faulted;
                inj_flag <= 1'b1;
                inj_mask <= mask;
            end else begin
                out_code <= in_code;
                inj_flag <= 1'b0;
                inj_mask <= '0;
            end
        end
    end

endmodule
